// File: rtl/ahfp_pkg.sv
// Shared single-precision helpers for the ahfp arithmetic blocks (mult/div).
// Field unpack with classification, and normalise + round-to-nearest-even pack.
package ahfp_pkg;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int ITER    = MAN_W + 3;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   typedef logic signed [EXP_W+1:0] sexp_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
   } fp_fields_t;

   function automatic fp_fields_t fp_unpack(input logic [31:0] x);
      fp_fields_t f;
      f.sign    = x[31];
      f.exp     = x[30:23];
      f.man     = x[22:0];
      f.is_nan  = (f.exp == '1) && (f.man != '0);
      f.is_inf  = (f.exp == '1) && (f.man == '0);
      // denormals count as zero: no subnormal support on either side
      f.is_zero = (f.exp == '0);
      return f;
   endfunction

   function automatic logic [31:0] rne_pack(input logic sign, input sexp_t e,
                                            input logic [ITER-1:0] q, input logic rem_nz);
      logic [MAN_W:0]   mant;
      logic             g;
      logic             s;
      sexp_t            ee;
      logic [MAN_W+1:0] mr;
      logic [31:0]      res;
      if (q[ITER-1]) begin
         mant = q[ITER-1:2];
         g    = q[1];
         s    = q[0] | rem_nz;
         ee   = e;
      end else begin
         mant = q[ITER-2:1];
         g    = q[0];
         s    = rem_nz;
         ee   = e - sexp_t'(1);
      end
      mr = {1'b0, mant} + {{(MAN_W+1){1'b0}}, g & (s | mant[0])};
      if (mr[MAN_W+1]) begin
         mr = mr >> 1;
         ee = ee + sexp_t'(1);
      end
      if (ee >= sexp_t'(EXP_MAX))
         res = {sign, POS_INF[30:0]};
      else if (ee <= sexp_t'(0))
         res = {sign, 31'b0};
      else
         res = {sign, ee[EXP_W-1:0], mr[MAN_W-1:0]};
      return res;
   endfunction
endpackage

// File: rtl/ahfp_div_mant_div.sv
// Restoring shift-subtract mantissa divider: one quotient bit per i_step, MSB first.
module ahfp_mant_div #(
   parameter int MAN_W = 23,
   parameter int ITER  = MAN_W + 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [MAN_W-1:0] i_ma,
   input  logic [MAN_W-1:0] i_mb,
   output logic [ITER-1:0]  o_q,
   output logic             o_rem_nz,
   output logic             o_last
);
   import ahfp_pkg::*;

   localparam int CW = $clog2(ITER + 1);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t LAST = cnt_t'(ITER - 1);

   logic [MAN_W+1:0] r_rem;
   logic [MAN_W:0]   r_div;
   logic [ITER-1:0]  r_q;
   cnt_t             r_cnt;
   logic             w_ge;
   logic [MAN_W+1:0] w_diff;

   assign w_ge   = r_rem >= {1'b0, r_div};
   assign w_diff = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

   // after a step the remainder is below the divisor, so the shifted value fits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rem <= '0;
         r_div <= '0;
         r_q   <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_rem <= {2'b01, i_ma};
         r_div <= {1'b1, i_mb};
         r_q   <= '0;
         r_cnt <= '0;
      end else if (i_step) begin
         r_rem <= {w_diff[MAN_W:0], 1'b0};
         r_q   <= {r_q[ITER-2:0], w_ge};
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_q      = r_q;
   assign o_rem_nz = (r_rem != '0);
   assign o_last   = (r_cnt == LAST);
endmodule

// File: rtl/ahfp_div.sv
// Iterative IEEE-754 single divider (result = dataa / datab) with start/done handshake.
// state  | meaning
// IDLE   | waiting for start; operands captured on accept
// LOAD   | classify operands; specials go straight to DONE
// DIV    | one quotient bit per clock, ITER steps
// ROUND  | normalise, RNE round, range check, pack
// DONE   | done pulse, result valid
module ahfp_div #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int ITER  = MAN_W + 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);
   import ahfp_pkg::*;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_DIV   = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]              r_state;
   logic [31:0]             r_a;
   logic [31:0]             r_b;
   logic                    r_sign;
   logic signed [EXP_W+1:0] r_exp;
   logic [31:0]             r_result;

   fp_fields_t              w_ua;
   fp_fields_t              w_ub;
   logic                    w_sign;
   logic signed [EXP_W+1:0] w_exp;
   logic                    w_special;
   logic [31:0]             w_spec_res;
   logic                    w_load;
   logic                    w_step;
   logic [ITER-1:0]         w_q;
   logic                    w_rem_nz;
   logic                    w_last;

   assign w_ua   = fp_unpack(r_a);
   assign w_ub   = fp_unpack(r_b);
   assign w_sign = w_ua.sign ^ w_ub.sign;
   assign w_exp  = signed'({2'b00, w_ua.exp}) - signed'({2'b00, w_ub.exp}) + sexp_t'(BIAS);

   // first matching case wins; NaN-producing forms take priority over inf/zero
   always_comb begin
      w_special  = 1'b1;
      w_spec_res = '0;
      if (w_ua.is_nan | w_ub.is_nan | (w_ua.is_zero & w_ub.is_zero) | (w_ua.is_inf & w_ub.is_inf))
         w_spec_res = QNAN;
      else if (w_ua.is_inf | w_ub.is_zero)
         w_spec_res = {w_sign, POS_INF[30:0]};
      else if (w_ua.is_zero | w_ub.is_inf)
         w_spec_res = {w_sign, 31'b0};
      else
         w_special = 1'b0;
   end

   assign w_load = (r_state == S_LOAD) && !w_special;
   assign w_step = (r_state == S_DIV);

   ahfp_mant_div #(
      .MAN_W (MAN_W),
      .ITER  (ITER)
   ) u_mant_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_ma     (w_ua.man),
      .i_mb     (w_ub.man),
      .o_q      (w_q),
      .o_rem_nz (w_rem_nz),
      .o_last   (w_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_a     <= dataa;
               r_b     <= datab;
               r_state <= S_LOAD;
            end
            S_LOAD: if (w_special) begin
               r_result <= w_spec_res;
               r_state  <= S_DONE;
            end else begin
               r_sign  <= w_sign;
               r_exp   <= w_exp;
               r_state <= S_DIV;
            end
            S_DIV: if (w_last) r_state <= S_ROUND;
            S_ROUND: begin
               r_result <= rne_pack(r_sign, r_exp, w_q, w_rem_nz);
               r_state  <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (r_state == S_LOAD) || (r_state == S_DIV) || (r_state == S_ROUND);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
endmodule

// File: tb/tb_ahfp_div.sv
// Self-checking bench for ahfp_div: directed cases plus randomized operands vs an integer model.
module tb_ahfp_div;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_exp = '0;

   ahfp_div dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .dataa   (dataa),
      .datab   (datab),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // exact quotient via wide integer division, then RNE on the leftover bits
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int     ea, eb, e;
      bit     s, za, zb, ia, ib, na, nb, sticky, up;
      longint ma, mb, num, q, keep, rb, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
      if (ia || zb) return {s, 8'hFF, 23'h0};
      if (za || ib) return {s, 31'h0};
      ma = 64'h800000 | longint'(a[22:0]);
      mb = 64'h800000 | longint'(b[22:0]);
      num = ma << 26;
      q = num / mb;
      sticky = (num % mb) != 0;
      e = ea - eb + 127;
      if (q >= (64'd1 << 26)) begin
         keep = q >> 3; rb = q & 7; half = 4;
      end else begin
         keep = q >> 2; rb = q & 3; half = 2; e = e - 1;
      end
      up = (rb > half) || ((rb == half) && (sticky || (keep % 2 == 1)));
      if (up) keep = keep + 1;
      if (keep == (64'd1 << 24)) begin
         keep = keep >> 1; e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, e[7:0], keep[22:0]};
   endfunction

   // lat: cycle index of done, where cycle 1 follows the accept edge; -1 on timeout
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit busy_ok, output logic busy_at_done);
      dataa = a; datab = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; busy_ok = 1'b1; res = 'x; busy_at_done = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            lat = c; res = result; busy_at_done = busy;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      logic [31:0] r; int lat; bit bok; logic bad;
      run_div(32'h40C00000, 32'h40000000, r, lat, bok, bad);
      checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL basic_result: got %h want 40400000", r); end
      checks++; if (lat !== 29) begin errors++; $display("FAIL basic_latency: got %0d want 29", lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy: busy dropped before done"); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bad); end
      last_exp = 32'h40400000;
   endtask

   task automatic test_round();
      logic [31:0] ta[2] = '{32'h3F800000, 32'hC0C00000};
      logic [31:0] tb[2] = '{32'h40400000, 32'h40000000};
      logic [31:0] te[2] = '{32'h3EAAAAAB, 32'hC0400000};
      logic [31:0] r; int lat; bit bok; logic bad;
      for (int i = 0; i < 2; i++) begin
         run_div(ta[i], tb[i], r, lat, bok, bad);
         checks++; if (r !== te[i]) begin errors++; $display("FAIL round_%0d: got %h want %h", i, r, te[i]); end
         checks++; if (lat !== 29) begin errors++; $display("FAIL round_lat_%0d: got %0d want 29", i, lat); end
         last_exp = te[i];
      end
   endtask

   task automatic test_specials();
      logic [31:0] ta[4] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h3F800000};
      logic [31:0] tb[4] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000};
      logic [31:0] te[4] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
      logic [31:0] r; int lat; bit bok; logic bad;
      for (int i = 0; i < 4; i++) begin
         run_div(ta[i], tb[i], r, lat, bok, bad);
         checks++; if (r !== te[i]) begin errors++; $display("FAIL special_%0d: got %h want %h", i, r, te[i]); end
         checks++; if (lat !== 2) begin errors++; $display("FAIL special_lat_%0d: got %0d want 2", i, lat); end
         last_exp = te[i];
      end
   endtask

   task automatic test_range();
      logic [31:0] ta[2] = '{32'h7F000000, 32'h00800000};
      logic [31:0] tb[2] = '{32'h00800000, 32'h7F000000};
      logic [31:0] te[2] = '{32'h7F800000, 32'h00000000};
      logic [31:0] r; int lat; bit bok; logic bad;
      for (int i = 0; i < 2; i++) begin
         run_div(ta[i], tb[i], r, lat, bok, bad);
         checks++; if (r !== te[i]) begin errors++; $display("FAIL range_%0d: got %h want %h", i, r, te[i]); end
         checks++; if (lat !== 29) begin errors++; $display("FAIL range_lat_%0d: got %0d want 29", i, lat); end
         last_exp = te[i];
      end
   endtask

   task automatic test_random();
      logic [31:0] pool[7] = '{32'h00000000, 32'h80000000, 32'h00000123, 32'h7F800000,
                               32'hFF800000, 32'h7FC00001, 32'h3F800000};
      logic [31:0] a, b, r, e; int lat, elat; bit bok; logic bad;
      for (int i = 0; i < 60; i++) begin
         a = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
         b = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
         if ($urandom_range(3, 0) == 0) a = pool[$urandom_range(6, 0)];
         if ($urandom_range(3, 0) == 0) b = pool[$urandom_range(6, 0)];
         e = ref_div(a, b);
         elat = (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF) ? 2 : 29;
         run_div(a, b, r, lat, bok, bad);
         checks++; if (r !== e) begin errors++; $display("FAIL random_%0d: %h/%h got %h want %h", i, a, b, r, e); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL random_lat_%0d: got %0d want %0d", i, lat, elat); end
         last_exp = e;
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      int first = -1;
      bit held = 1'b1;
      dataa = 32'h3F800000; datab = 32'h40400000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 10) begin start = 1'b1; dataa = 32'h40C00000; datab = 32'h40000000; end
         if (c == 11) start = 1'b0;
         if (done) begin
            ndone++;
            if (first < 0) first = c;
         end else if (first < 0 && result !== last_exp) held = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
      checks++; if (first !== 29) begin errors++; $display("FAIL ignore_latency: got %0d want 29", first); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL ignore_held: result changed before done"); end
      checks++; if (result !== 32'h3EAAAAAB) begin errors++; $display("FAIL ignore_result: got %h want 3eaaaaab", result); end
      last_exp = 32'h3EAAAAAB;
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int n = -1;
      dataa = 32'h40C00000; datab = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin first = c; break; end
         @(posedge clk); #1;
      end
      checks++; if (first !== 29) begin errors++; $display("FAIL b2b_first_lat: got %0d want 29", first); end
      checks++; if (result !== 32'h40400000) begin errors++; $display("FAIL b2b_first: got %h want 40400000", result); end
      dataa = 32'h3F800000; datab = 32'h40400000;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 2) start = 1'b0;
         if (done) begin n = c; break; end
      end
      start = 1'b0;
      checks++; if (n !== 30) begin errors++; $display("FAIL b2b_second_lat: got %0d want 30", n); end
      checks++; if (result !== 32'h3EAAAAAB) begin errors++; $display("FAIL b2b_second: got %h want 3eaaaaab", result); end
      @(posedge clk); #1;
      last_exp = 32'h3EAAAAAB;
   endtask

   task automatic test_reset_mid();
      bit quiet = 1'b1;
      logic [31:0] r; int lat; bit bok; logic bad;
      dataa = 32'h40C00000; datab = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 00000000", result); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL midrst_quiet: activity after reset release"); end
      run_div(32'h40C00000, 32'h40000000, r, lat, bok, bad);
      checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL midrst_rerun: got %h want 40400000", r); end
      checks++; if (lat !== 29) begin errors++; $display("FAIL midrst_rerun_lat: got %0d want 29", lat); end
      last_exp = 32'h40400000;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round();
      test_specials();
      test_range();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
